// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the sequential chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Number of chunk passes needed to cover the full operand width.
  function automatic int unsigned calc_nch(input int unsigned width, input int unsigned chunk);
    return width / chunk;
  endfunction

  // Chunk index width; a single-chunk configuration still gets one bit.
  function automatic int unsigned idx_width(input int unsigned nch);
    return (nch <= 1) ? 1 : $clog2(nch);
  endfunction

endpackage

// File: rtl/seq_chunk_adder_if.sv
// Request/result bundle between a requester and the sequential chunked adder.
interface seq_chunk_adder_if #(
  parameter int unsigned WIDTH = 64
);
  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             overflow;

  modport master (
    output start, sub, cin, a, b,
    input  busy, done, sum, cout, overflow
  );

  modport slave (
    input  start, sub, cin, a, b,
    output busy, done, sum, cout, overflow
  );
endinterface

// File: rtl/Full_adder.sv
// Single-bit full adder cell.
module Full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/chunk_ripple_adder.sv
// CHUNK-bit combinational ripple chain; also exposes the carry into its MSB.
module chunk_ripple_adder #(
  parameter int unsigned CHUNK = 16
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);
  logic [CHUNK:0] carry;

  assign carry[0] = c_i;

  for (genvar g = 0; g < CHUNK; g++) begin : g_fa
    Full_adder u_fa (
      .a_i (a_i[g]),
      .b_i (b_i[g]),
      .c_i (carry[g]),
      .s_o (s_o[g]),
      .c_o (carry[g+1])
    );
  end

  assign c_o     = carry[CHUNK];
  assign c_msb_o = carry[CHUNK-1];
endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract: latches operands on start, then ripples one chunk per clock.
module seq_chunk_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CHUNK = 16
) (
  input  logic               clk,
  input  logic               rst,
  seq_chunk_adder_if.slave   bus
);
  localparam int unsigned NCH   = calc_nch(WIDTH, CHUNK);
  localparam int unsigned IDX_W = idx_width(NCH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               carry_q, carry_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [CHUNK-1:0]   a_chunk, b_chunk, s_chunk;
  logic               c_chunk, c_msb;

  // Select the operand chunk addressed by the current index.
  always_comb begin
    a_chunk = '0;
    b_chunk = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (idx_q == IDX_W'(k)) begin
        a_chunk = a_q[k*CHUNK +: CHUNK];
        b_chunk = b_q[k*CHUNK +: CHUNK];
      end
    end
  end

  chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (a_chunk),
    .b_i     (b_chunk),
    .c_i     (carry_q),
    .s_o     (s_chunk),
    .c_o     (c_chunk),
    .c_msb_o (c_msb)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic: accept in IDLE/DONE, one chunk per RUN cycle, single-cycle done pulse.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          // Subtraction folds into addition: A + ~B + ~borrow.
          a_d     = bus.a;
          b_d     = bus.sub ? ~bus.b : bus.b;
          carry_d = bus.cin ^ bus.sub;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        for (int unsigned k = 0; k < NCH; k++) begin
          if (idx_q == IDX_W'(k)) begin
            sum_d[k*CHUNK +: CHUNK] = s_chunk;
          end
        end
        carry_d = c_chunk;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = c_chunk;
          ovf_d   = c_msb ^ c_chunk;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder: 64/16 main instance plus an 8/8 single-chunk instance.
module tb_seq_chunk_adder;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_fail;

  seq_chunk_adder_if #(.WIDTH(64)) ifa ();
  seq_chunk_adder_if #(.WIDTH(8))  if8 ();

  seq_chunk_adder #(.WIDTH(64), .CHUNK(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Issue one 64-bit operation now and check busy/done timing and the final result.
  task automatic op64(input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic s, input logic c, input logic [63:0] es,
                      input logic ec, input logic eo);
    ifa.start = 1'b1;
    ifa.a     = a;
    ifa.b     = b;
    ifa.sub   = s;
    ifa.cin   = c;
    step();
    ifa.start = 1'b0;
    chk_bit({tag, "_busy_t0"}, ifa.busy, 1'b1);
    chk_bit({tag, "_done_t0"}, ifa.done, 1'b0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk_bit({tag, "_busy_run"}, ifa.busy, 1'b1);
      chk_bit({tag, "_done_run"}, ifa.done, 1'b0);
    end
    step();
    chk_bit({tag, "_busy_end"}, ifa.busy, 1'b0);
    chk_bit({tag, "_done"}, ifa.done, 1'b1);
    chk({tag, "_sum"}, ifa.sum, es);
    chk_bit({tag, "_cout"}, ifa.cout, ec);
    chk_bit({tag, "_ovf"}, ifa.overflow, eo);
  endtask

  initial begin
    n_vec      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    ifa.start  = 1'b0;
    ifa.sub    = 1'b0;
    ifa.cin    = 1'b0;
    ifa.a      = '0;
    ifa.b      = '0;
    if8.start  = 1'b0;
    if8.sub    = 1'b0;
    if8.cin    = 1'b0;
    if8.a      = '0;
    if8.b      = '0;

    step();
    step();
    chk_bit("rst_busy", ifa.busy, 1'b0);
    chk_bit("rst_done", ifa.done, 1'b0);
    chk("rst_sum", ifa.sum, 64'h0);
    chk_bit("rst_cout", ifa.cout, 1'b0);
    chk_bit("rst_ovf", ifa.overflow, 1'b0);
    chk_bit("rst8_done", if8.done, 1'b0);
    rst = 1'b0;
    step();

    // Wrap-around: all-ones + 1.
    op64("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
    step();
    chk_bit("wrap_done_drop", ifa.done, 1'b0);
    chk("wrap_sum_hold", ifa.sum, 64'h0);

    // Signed overflow on add.
    op64("sovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    step();

    // Subtract with borrow-in: 5 - 7 - 1 = -3.
    op64("subb", 64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 1'b0);
    step();
    chk_bit("subb_done_drop", ifa.done, 1'b0);
    chk("subb_sum_hold", ifa.sum, 64'hFFFF_FFFF_FFFF_FFFD);

    // Handshake: start while busy is ignored.
    ifa.start = 1'b1;
    ifa.a     = 64'h1234;
    ifa.b     = 64'h1;
    ifa.sub   = 1'b0;
    ifa.cin   = 1'b0;
    step();
    ifa.start = 1'b0;
    step();
    ifa.start = 1'b1;
    ifa.a     = 64'hDEAD_BEEF_0000_0000;
    ifa.b     = 64'hFFFF_FFFF_FFFF_FFFF;
    ifa.sub   = 1'b1;
    ifa.cin   = 1'b1;
    step();
    ifa.start = 1'b0;
    chk_bit("ign_busy2", ifa.busy, 1'b1);
    step();
    chk_bit("ign_done3", ifa.done, 1'b0);
    step();
    chk_bit("ign_done", ifa.done, 1'b1);
    chk("ign_sum", ifa.sum, 64'h1235);
    chk_bit("ign_cout", ifa.cout, 1'b0);
    chk_bit("ign_ovf", ifa.overflow, 1'b0);
    // Back-to-back start accepted in the done cycle.
    op64("b2b", 64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0,
         64'h0000_0001_FFFF_FFFF, 1'b0, 1'b0);
    step();
    chk_bit("b2b_done_drop", ifa.done, 1'b0);

    // Reset mid-operation clears outputs without a clock edge.
    ifa.start = 1'b1;
    ifa.a     = 64'h1111_1111_1111_1111;
    ifa.b     = 64'h2222_2222_2222_2222;
    ifa.sub   = 1'b0;
    ifa.cin   = 1'b0;
    step();
    ifa.start = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk_bit("mrst_busy", ifa.busy, 1'b0);
    chk_bit("mrst_done", ifa.done, 1'b0);
    chk("mrst_sum", ifa.sum, 64'h0);
    chk_bit("mrst_cout", ifa.cout, 1'b0);
    chk_bit("mrst_ovf", ifa.overflow, 1'b0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_bit("mrst_no_done", ifa.done, 1'b0);
      chk_bit("mrst_no_busy", ifa.busy, 1'b0);
    end
    op64("post_rst", 64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0);
    step();

    // Single-chunk configuration: 0x80 + 0x80.
    if8.start = 1'b1;
    if8.a     = 8'h80;
    if8.b     = 8'h80;
    if8.sub   = 1'b0;
    if8.cin   = 1'b0;
    step();
    if8.start = 1'b0;
    chk_bit("n1_busy", if8.busy, 1'b1);
    chk_bit("n1_done_t0", if8.done, 1'b0);
    step();
    chk_bit("n1_done", if8.done, 1'b1);
    chk_bit("n1_busy_end", if8.busy, 1'b0);
    chk("n1_sum", 64'(if8.sum), 64'h0);
    chk_bit("n1_cout", if8.cout, 1'b1);
    chk_bit("n1_ovf", if8.overflow, 1'b1);
    // Back-to-back subtract on the single-chunk instance: 0x10 - 0x20 = 0xF0.
    if8.start = 1'b1;
    if8.a     = 8'h10;
    if8.b     = 8'h20;
    if8.sub   = 1'b1;
    if8.cin   = 1'b0;
    step();
    if8.start = 1'b0;
    chk_bit("n1s_done_t0", if8.done, 1'b0);
    step();
    chk_bit("n1s_done", if8.done, 1'b1);
    chk("n1s_sum", 64'(if8.sum), 64'hF0);
    chk_bit("n1s_cout", if8.cout, 1'b0);
    chk_bit("n1s_ovf", if8.overflow, 1'b0);
    step();
    chk_bit("n1s_done_drop", if8.done, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
